// File: rtl/parcel_color_detector.sv
// Parcel colour classifier: averages VEML R/B/W words over 2^AVG_LOG2 sets and reports red/blue.
// Optional feature macro COLOR_HYST_EN: a colour commits only after two agreeing decisive windows.
module parcel_color_detector #(
    parameter int AVG_LOG2 = 2,
    parameter int MARGIN   = 64,
    parameter int DARK_TH  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ch_data,
    input  logic        ch_valid,
    input  logic        ch_first,
    output logic        ch_ready,
    output logic        veml_ready,
    output logic        parcel_color,
    output logic        color_valid,
    output logic        sync_err,
    output logic        state_dbg
);

    // Handshake: a word transfers on a rising edge where ch_valid & ch_ready are both high;
    // ch_ready drops only for the CLASSIFY cycle and the source must hold its word meanwhile.
    localparam int SW = 16 + AVG_LOG2;
    localparam int CW = 17 + AVG_LOG2;
    localparam logic [CW-1:0] DARK_LIM   = CW'(DARK_TH << AVG_LOG2);
    localparam logic [CW-1:0] MARGIN_LIM = CW'(MARGIN << AVG_LOG2);
    localparam logic [AVG_LOG2-1:0] SET_LAST = '1;

    typedef enum logic {ACC, CLASSIFY} state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [AVG_LOG2-1:0] set_cnt_q, set_cnt_d;
    logic [15:0]         r_sh_q, r_sh_d, b_sh_q, b_sh_d;
    logic [SW-1:0]       r_sum_q, r_sum_d, b_sum_q, b_sum_d, w_sum_q, w_sum_d;
    logic                ch_ready_q, ch_ready_d;
    logic                veml_ready_q, veml_ready_d;
    logic                color_q, color_d;
    logic                color_valid_q, color_valid_d;
    logic                sync_err_q, sync_err_d;
`ifdef COLOR_HYST_EN
    logic                cand_q, cand_d, cand_vld_q, cand_vld_d;
`endif

    logic [CW-1:0] r_ext, b_ext, w_ext;
    logic          is_dark, is_red, is_blue, commit;

    assign r_ext   = {1'b0, r_sum_q};
    assign b_ext   = {1'b0, b_sum_q};
    assign w_ext   = {1'b0, w_sum_q};
    assign is_dark = w_ext < DARK_LIM;
    assign is_red  = !is_dark && (r_ext > b_ext + MARGIN_LIM);
    assign is_blue = !is_dark && (b_ext > r_ext + MARGIN_LIM);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        set_cnt_d     = set_cnt_q;
        r_sh_d        = r_sh_q;
        b_sh_d        = b_sh_q;
        r_sum_d       = r_sum_q;
        b_sum_d       = b_sum_q;
        w_sum_d       = w_sum_q;
        ch_ready_d    = ch_ready_q;
        veml_ready_d  = 1'b0;
        color_d       = color_q;
        color_valid_d = color_valid_q;
        sync_err_d    = sync_err_q;
        commit        = 1'b0;
`ifdef COLOR_HYST_EN
        cand_d        = cand_q;
        cand_vld_d    = cand_vld_q;
`endif
        case (state_q)
            ACC: begin
                if (ch_valid) begin
                    if (ch_first && idx_q != 2'd0) begin
                        // Partial words live only in shadows, so restarting the set needs no undo.
                        sync_err_d = 1'b1;
                        r_sh_d     = ch_data;
                        b_sh_d     = '0;
                        idx_d      = 2'd1;
                    end else if (!ch_first && idx_q == 2'd0) begin
                        sync_err_d = 1'b1;
                    end else begin
                        case (idx_q)
                            2'd0: begin r_sh_d = ch_data; idx_d = 2'd1; end
                            2'd1: idx_d = 2'd2;
                            2'd2: begin b_sh_d = ch_data; idx_d = 2'd3; end
                            default: begin
                                r_sum_d = r_sum_q + SW'(r_sh_q);
                                b_sum_d = b_sum_q + SW'(b_sh_q);
                                w_sum_d = w_sum_q + SW'(ch_data);
                                idx_d   = 2'd0;
                                if (set_cnt_q == SET_LAST) begin
                                    set_cnt_d  = '0;
                                    state_d    = CLASSIFY;
                                    ch_ready_d = 1'b0;
                                end else begin
                                    set_cnt_d = set_cnt_q + 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            default: begin
                if (is_red || is_blue) begin
`ifdef COLOR_HYST_EN
                    commit     = cand_vld_q && (cand_q == is_blue);
                    cand_d     = is_blue;
                    cand_vld_d = 1'b1;
`else
                    commit     = 1'b1;
`endif
                end
`ifdef COLOR_HYST_EN
                else begin
                    cand_vld_d = 1'b0;
                end
`endif
                if (commit) begin
                    color_d       = is_blue;
                    color_valid_d = 1'b1;
                    veml_ready_d  = 1'b1;
                end
                r_sum_d    = '0;
                b_sum_d    = '0;
                w_sum_d    = '0;
                set_cnt_d  = '0;
                ch_ready_d = 1'b1;
                state_d    = ACC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ACC;
            idx_q         <= '0;
            set_cnt_q     <= '0;
            r_sh_q        <= '0;
            b_sh_q        <= '0;
            r_sum_q       <= '0;
            b_sum_q       <= '0;
            w_sum_q       <= '0;
            ch_ready_q    <= 1'b1;
            veml_ready_q  <= 1'b0;
            color_q       <= 1'b0;
            color_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef COLOR_HYST_EN
            cand_q        <= 1'b0;
            cand_vld_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            set_cnt_q     <= set_cnt_d;
            r_sh_q        <= r_sh_d;
            b_sh_q        <= b_sh_d;
            r_sum_q       <= r_sum_d;
            b_sum_q       <= b_sum_d;
            w_sum_q       <= w_sum_d;
            ch_ready_q    <= ch_ready_d;
            veml_ready_q  <= veml_ready_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            sync_err_q    <= sync_err_d;
`ifdef COLOR_HYST_EN
            cand_q        <= cand_d;
            cand_vld_q    <= cand_vld_d;
`endif
        end
    end

    assign ch_ready     = ch_ready_q;
    assign veml_ready   = veml_ready_q;
    assign parcel_color = color_q;
    assign color_valid  = color_valid_q;
    assign sync_err     = sync_err_q;
    assign state_dbg    = (state_q == CLASSIFY);

endmodule

// File: tb/tb_parcel_color_detector.sv
// Bench for parcel_color_detector: directed windows plus random windows against a sum-based model.
module tb_parcel_color_detector;
    localparam int AVG_LOG2 = 2;
    localparam int MARGIN   = 64;
    localparam int DARK_TH  = 256;
    localparam int SETS     = 1 << AVG_LOG2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ch_data;
    logic        ch_valid, ch_first;
    logic        ch_ready, veml_ready, parcel_color, color_valid, sync_err, state_dbg;

    int checks   = 0;
    int failures = 0;

    // Reference model: running window totals and the expected visible outputs.
    int   m_r, m_b, m_w;
    logic exp_color, exp_cvalid, exp_pulse, exp_sync;
    logic m_cand, m_cand_vld;

    parcel_color_detector #(.AVG_LOG2(AVG_LOG2), .MARGIN(MARGIN), .DARK_TH(DARK_TH)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid), .ch_first(ch_first),
        .ch_ready(ch_ready), .veml_ready(veml_ready), .parcel_color(parcel_color),
        .color_valid(color_valid), .sync_err(sync_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_r = 0; m_b = 0; m_w = 0;
    endtask

    task automatic do_reset();
        ch_valid = 1'b0; ch_first = 1'b0; ch_data = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        exp_color = 1'b0; exp_cvalid = 1'b0; exp_sync = 1'b0;
        m_cand = 1'b0; m_cand_vld = 1'b0;
        check("rst_ch_ready", ch_ready, 1);
        check("rst_veml_ready", veml_ready, 0);
        check("rst_parcel_color", parcel_color, 0);
        check("rst_color_valid", color_valid, 0);
        check("rst_sync_err", sync_err, 0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge, valid still high.
    task automatic send_word(input logic [15:0] d, input logic f);
        int guard = 0;
        ch_data = d; ch_first = f; ch_valid = 1'b1;
        while (ch_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard == 8) check("ch_ready_wait", ch_ready, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_set(input int r, input int g, input int b, input int w);
        send_word(16'(r), 1'b1);
        send_word(16'(g), 1'b0);
        send_word(16'(b), 1'b0);
        send_word(16'(w), 1'b0);
        m_r += r; m_b += b; m_w += w;
    endtask

    // Called right after the final W word was accepted.
    task automatic end_window(input string tag);
        logic dark, red, blue;
        ch_valid = 1'b0;
        dark = m_w < DARK_TH * SETS;
        red  = !dark && (m_r > m_b + MARGIN * SETS);
        blue = !dark && (m_b > m_r + MARGIN * SETS);
        exp_pulse = 1'b0;
        if (red || blue) begin
`ifdef COLOR_HYST_EN
            if (m_cand_vld && m_cand == blue) exp_pulse = 1'b1;
            m_cand = blue; m_cand_vld = 1'b1;
`else
            exp_pulse = 1'b1;
`endif
        end else begin
            m_cand_vld = 1'b0;
        end
        if (exp_pulse) begin
            exp_color = blue; exp_cvalid = 1'b1;
        end
        model_clear();
        check({tag, "_classify_ready"}, ch_ready, 0);
        check({tag, "_early_pulse"}, veml_ready, 0);
        @(negedge clk);
        check({tag, "_pulse"}, veml_ready, exp_pulse);
        check({tag, "_color"}, parcel_color, exp_color);
        check({tag, "_color_valid"}, color_valid, exp_cvalid);
        check({tag, "_ready_back"}, ch_ready, 1);
        check({tag, "_sync_err"}, sync_err, exp_sync);
        @(negedge clk);
        check({tag, "_pulse_end"}, veml_ready, 0);
    endtask

    initial begin
        rst = 1'b1; ch_valid = 1'b0; ch_first = 1'b0; ch_data = '0;
        @(negedge clk);
        do_reset();

        // Red windows; the repeat commits the same colour again and must still pulse.
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < SETS; s++) send_set(1000, 500, 200, 2000);
            end_window("red");
        end
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < SETS; s++) send_set(200, 500, 1000, 2000);
            end_window("blue");
        end
        for (int s = 0; s < SETS; s++) send_set(500, 500, 500, 2000);
        end_window("ambiguous");
        for (int s = 0; s < SETS; s++) send_set(1000, 500, 0, 100);
        end_window("dark");

        // Restart on the B word of set 2: the partial R=1000 must not reach the sums.
        send_set(100, 50, 300, 2000);
        send_word(16'd1000, 1'b1);
        send_word(16'd50, 1'b0);
        send_word(16'd100, 1'b1);
        exp_sync = 1'b1;
        send_word(16'd50, 1'b0);
        send_word(16'd300, 1'b0);
        send_word(16'd2000, 1'b0);
        m_r += 100; m_b += 300; m_w += 2000;
        check("restart_sync_err", sync_err, 1);
        for (int s = 0; s < 2; s++) send_set(100, 50, 300, 2000);
        end_window("restart");

        // Word without ch_first at index 0 is dropped.
        do_reset();
        send_word(16'd9999, 1'b0);
        exp_sync = 1'b1;
        check("drop_sync_err", sync_err, 1);
        for (int s = 0; s < SETS; s++) send_set(1000, 500, 200, 2000);
        end_window("drop_red");

        // Reset in the middle of a window.
        for (int s = 0; s < SETS - 1; s++) send_set(1000, 500, 200, 2000);
        ch_valid = 1'b0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < SETS; s++) send_set(1000, 500, 200, 2000);
            end_window("post_rst_red");
        end

        // Random windows; a bias per window makes decisive outcomes common.
        for (int k = 0; k < 10; k++) begin
            int bias = $urandom_range(0, 2);
            for (int s = 0; s < SETS; s++) begin
                int r = $urandom_range(0, 1200);
                int b = $urandom_range(0, 1200);
                if (bias == 0) r += 300;
                if (bias == 1) b += 300;
                send_set(r, $urandom_range(0, 65535), b, $urandom_range(0, 3000));
            end
            end_window("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
